// File: rtl/exanet_crosb_pkg.sv
// Shared types and header field map for the ExaNet crossbar VC routing unit.
// Holds the route FSM states, router modes, control-info layout and address helper.
package exanet_crosb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DECODE = 3'd1,
      ST_ROUTE  = 3'd2,
      ST_HOLD   = 3'd3,
      ST_DROP   = 3'd4
   } route_state_e;

   typedef enum logic [1:0] {
      MODE_INTER   = 2'd0,
      MODE_CENTRAL = 2'd1,
      MODE_NI      = 2'd2
   } router_mode_e;

   localparam int CI_PORT_W = 3;

   typedef struct packed {
      router_mode_e                   mode;
      logic                           multipath_enable;
      logic [CI_PORT_W-1:0]           local_port;
      logic [CI_PORT_W-1:0]           dest_y_port;
      logic [3:0][CI_PORT_W-1:0]      dest_x_port;   // [0] is x0
   } cntrl_info_t;

   localparam int DST_X_HI        = 24;
   localparam int DST_X_LO        = 21;
   localparam int DST_Y_HI        = 28;
   localparam int DST_Y_LO        = 25;
   localparam int DST_Z_HI        = 32;
   localparam int DST_Z_LO        = 29;
   localparam int DST_OFF_HI      = 34;
   localparam int DST_OFF_LO      = 33;
   localparam int PATH_HI         = 111;
   localparam int PATH_LO         = 109;
   localparam int PKT_TYPE_HI     = 12;
   localparam int PKT_TYPE_LO     = 8;
   localparam int PKT_SIZE_HI     = 20;
   localparam int PKT_SIZE_LO     = 13;
   localparam int PKT_DST_VA_HI   = 76;
   localparam int PKT_DST_VA_LO   = 35;
   localparam int EXA_ADDR_HI     = 71;
   localparam int EXA_ADDR_LO     = 62;
   localparam int PKT_TYPE_W      = PKT_TYPE_HI - PKT_TYPE_LO + 1;

   localparam logic [PKT_TYPE_W-1:0] EXA_TYPE_MIN  = 5'd10;
   localparam logic [PKT_TYPE_W-1:0] PRIO_TYPE_MIN = 5'd16;

   // The exa-address field lives inside the VA range, so it is taken from the VA slice.
   function automatic logic [41:0] exa_addr(input logic [PKT_TYPE_W-1:0] ptype,
                                            input logic [41:0]            va);
      if (ptype >= EXA_TYPE_MIN)
         return {3'b111, 29'b0, va[EXA_ADDR_HI-PKT_DST_VA_LO:EXA_ADDR_LO-PKT_DST_VA_LO]};
      return va;
   endfunction

endpackage

// File: rtl/exa_crosb_route_decode.sv
// Combinational mode/address decode: minimal output port, decode error, and whether the minimal hop is the Y port.
// Zero latency, no state, no backpressure.
module exa_crosb_route_decode
   import exanet_crosb_pkg::*;
#(
   parameter int          TDEST_WIDTH = 3,
   parameter int          OUTPUT_NUM  = 4,
   parameter int          MAX_PORTS   = 32,
   parameter logic [41:0] PORT_LOW_ADDR  [MAX_PORTS] = '{default: 42'h0},
   parameter logic [41:0] PORT_HIGH_ADDR [MAX_PORTS] = '{default: 42'h0}
) (
   input  logic [127:0]             hdr_i,
   input  logic [21:0]              src_coord_i,
   input  cntrl_info_t              cntrl_i,
   output logic [TDEST_WIDTH-1:0]   tdest_o,
   output logic                     err_o,
   output logic                     min_is_y_o
);

   logic [3:0]             dst_x, dst_y, src_x, src_y;
   logic [1:0]             dst_off, src_off;
   logic [2:0]             path;
   logic [41:0]            addr;
   logic                   win_hit;
   logic [TDEST_WIDTH-1:0] win_idx;
   logic                   unused_bits;

   assign dst_x   = hdr_i[DST_X_HI:DST_X_LO];
   assign dst_y   = hdr_i[DST_Y_HI:DST_Y_LO];
   assign dst_off = hdr_i[DST_OFF_HI:DST_OFF_LO];
   assign path    = hdr_i[PATH_HI:PATH_LO];
   assign src_x   = src_coord_i[3:0];
   assign src_y   = src_coord_i[7:4];
   assign src_off = src_coord_i[13:12];
   assign addr    = exa_addr(hdr_i[PKT_TYPE_HI:PKT_TYPE_LO], hdr_i[PKT_DST_VA_HI:PKT_DST_VA_LO]);

   assign unused_bits = ^{hdr_i[127:112], hdr_i[108:77], hdr_i[DST_Z_HI:DST_Z_LO],
                          hdr_i[PKT_SIZE_HI:PKT_SIZE_LO], hdr_i[7:0],
                          src_coord_i[21:14], src_coord_i[11:8]};

   // Later windows overwrite earlier ones, so the highest matching index wins.
   always_comb begin
      win_hit = 1'b0;
      win_idx = '0;
      for (int i = 0; i < OUTPUT_NUM; i++) begin
         if (addr >= PORT_LOW_ADDR[i] && addr <= PORT_HIGH_ADDR[i]) begin
            win_hit = 1'b1;
            win_idx = TDEST_WIDTH'(i);
         end
      end
   end

   always_comb begin
      tdest_o    = '0;
      err_o      = 1'b0;
      min_is_y_o = 1'b0;
      unique case (cntrl_i.mode)
         MODE_INTER: begin
            if (dst_x == src_x && dst_y == src_y)
               tdest_o = TDEST_WIDTH'(cntrl_i.local_port) + TDEST_WIDTH'(dst_off);
            else if (cntrl_i.multipath_enable && path >= 3'd1 && path <= 3'd4)
               tdest_o = TDEST_WIDTH'(cntrl_i.dest_x_port[2'(path - 3'd1)]);
            else if (dst_y != src_y) begin
               tdest_o    = TDEST_WIDTH'(cntrl_i.dest_y_port);
               min_is_y_o = 1'b1;
            end
            else if (dst_x < 4'd4)
               tdest_o = TDEST_WIDTH'(cntrl_i.dest_x_port[dst_x[1:0]]);
            else
               err_o = 1'b1;
         end
         MODE_CENTRAL: tdest_o = TDEST_WIDTH'(dst_y);
         MODE_NI: begin
            if (dst_x != src_x || dst_y != src_y)
               tdest_o = '0;
            else if (dst_off != src_off)
               tdest_o = (src_off == 2'd0) ? '0 : TDEST_WIDTH'(dst_off);
            else if (win_hit)
               tdest_o = win_idx;
            else
               err_o = 1'b1;
         end
         default: err_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/exa_crosb_vc_routing.sv
// Per-input route unit: decodes a header once, picks port/VC, optionally diverts onto a free X port, holds the route per packet.
// Route request from 2 cycles after header; holds o_dest_valid until i_dest_ready, then freezes until i_pkt_done.
module exa_crosb_vc_routing
   import exanet_crosb_pkg::*;
#(
   parameter int          TDEST_WIDTH   = 3,
   parameter int          OUTPUT_NUM    = 4,
   parameter int          MAX_PORTS     = 32,
   parameter logic [41:0] PORT_LOW_ADDR  [MAX_PORTS] = '{default: 42'h0},
   parameter logic [41:0] PORT_HIGH_ADDR [MAX_PORTS] = '{default: 42'h0},
   parameter int          NUM_VC        = 2,
   parameter bit          ADAPTIVE_EN   = 1'b0,
   parameter int          ERR_CNT_WIDTH = 16,
   localparam int         VC_WIDTH      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
   input  logic                       Clk,
   input  logic                       Resetn,
   input  logic [127:0]               i_header,
   input  logic                       i_hdr_valid,
   input  logic [21:0]                i_src_coord,
   input  cntrl_info_t                i_cntrl_info,
   input  logic [OUTPUT_NUM-1:0]      i_port_busy,
   input  logic                       i_dest_ready,
   input  logic                       i_pkt_done,
   input  logic                       i_err_clr,
   output logic [127:0]               o_header,
   output logic [TDEST_WIDTH-1:0]     o_tdest,
   output logic [VC_WIDTH-1:0]        o_vc,
   output logic                       o_prio,
   output logic                       o_dest_valid,
   output logic                       o_drop,
   output logic                       o_dec_error,
   output logic [ERR_CNT_WIDTH-1:0]   o_err_cnt
);

   localparam int                  NPORT   = 1 << TDEST_WIDTH;
   localparam logic [VC_WIDTH-1:0] VC_PRIO = VC_WIDTH'(NUM_VC - 1);
   localparam logic [VC_WIDTH-1:0] VC_ALT  = VC_WIDTH'((NUM_VC > 1) ? 1 : 0);

   route_state_e               state_q, state_d;
   logic [TDEST_WIDTH-1:0]     tdest_q, tdest_d;
   logic [VC_WIDTH-1:0]        vc_q, vc_d;
   logic [127:0]               hdr_q, hdr_d;
   logic                       prio_q, prio_d;
   logic [1:0]                 ptr_q, ptr_d;
   logic                       err_q, err_d;
   logic [ERR_CNT_WIDTH-1:0]   cnt_q, cnt_d;

   logic [TDEST_WIDTH-1:0]     dec_tdest, route_tdest;
   logic                       dec_err, dec_min_y;
   logic [NPORT-1:0]           busy_ext;
   logic [2:0]                 path_in, path_out;
   logic                       inter_mp, try_div, div_hit, diverted, prio;
   logic [1:0]                 div_idx, idx;
   logic [VC_WIDTH-1:0]        vc_sel;

   exa_crosb_route_decode #(
      .TDEST_WIDTH    (TDEST_WIDTH),
      .OUTPUT_NUM     (OUTPUT_NUM),
      .MAX_PORTS      (MAX_PORTS),
      .PORT_LOW_ADDR  (PORT_LOW_ADDR),
      .PORT_HIGH_ADDR (PORT_HIGH_ADDR)
   ) u_decode (
      .hdr_i       (i_header),
      .src_coord_i (i_src_coord),
      .cntrl_i     (i_cntrl_info),
      .tdest_o     (dec_tdest),
      .err_o       (dec_err),
      .min_is_y_o  (dec_min_y)
   );

   // Ports beyond OUTPUT_NUM read as never busy.
   assign busy_ext = NPORT'(i_port_busy);
   assign path_in  = i_header[PATH_HI:PATH_LO];
   assign prio     = i_header[PKT_TYPE_HI:PKT_TYPE_LO] > PRIO_TYPE_MIN;
   assign inter_mp = (i_cntrl_info.mode == MODE_INTER) && i_cntrl_info.multipath_enable;
   assign try_div  = ADAPTIVE_EN && inter_mp && (path_in == 3'd0) && dec_min_y && !dec_err
                     && busy_ext[TDEST_WIDTH'(i_cntrl_info.dest_y_port)];

   always_comb begin
      div_hit = 1'b0;
      div_idx = '0;
      idx     = '0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr_q + 2'(k);
         if (!div_hit && !busy_ext[TDEST_WIDTH'(i_cntrl_info.dest_x_port[idx])]) begin
            div_hit = 1'b1;
            div_idx = idx;
         end
      end
   end

   assign diverted    = try_div && div_hit;
   assign route_tdest = diverted ? TDEST_WIDTH'(i_cntrl_info.dest_x_port[div_idx]) : dec_tdest;

   always_comb begin
      path_out = path_in;
      if (diverted)
         path_out = 3'(div_idx) + 3'd1;
      else if (inter_mp)
         path_out = 3'd0;
      vc_sel = '0;
      if (prio)
         vc_sel = VC_PRIO;
      else if (diverted || path_in != 3'd0)
         vc_sel = VC_ALT;
   end

   always_comb begin
      state_d = state_q;
      tdest_d = tdest_q;
      vc_d    = vc_q;
      hdr_d   = hdr_q;
      prio_d  = prio_q;
      ptr_d   = ptr_q;
      err_d   = i_err_clr ? 1'b0 : err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: if (i_hdr_valid) state_d = ST_DECODE;
         ST_DECODE: begin
            tdest_d                 = route_tdest;
            vc_d                    = vc_sel;
            hdr_d                   = i_header;
            hdr_d[PATH_HI:PATH_LO]  = path_out;
            prio_d                  = prio;
            if (dec_err) begin
               state_d = ST_DROP;
               err_d   = 1'b1;
               if (cnt_q != '1) cnt_d = cnt_q + ERR_CNT_WIDTH'(1);
            end else begin
               state_d = ST_ROUTE;
               if (diverted) ptr_d = div_idx + 2'd1;
            end
         end
         ST_ROUTE: if (i_dest_ready) state_d = i_pkt_done ? ST_IDLE : ST_HOLD;
         ST_HOLD:  if (i_pkt_done) state_d = ST_IDLE;
         ST_DROP:  if (i_pkt_done) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= ST_IDLE;
         tdest_q <= '0;
         vc_q    <= '0;
         hdr_q   <= '0;
         prio_q  <= 1'b0;
         ptr_q   <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         tdest_q <= tdest_d;
         vc_q    <= vc_d;
         hdr_q   <= hdr_d;
         prio_q  <= prio_d;
         ptr_q   <= ptr_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_header     = hdr_q;
   assign o_tdest      = tdest_q;
   assign o_vc         = vc_q;
   assign o_prio       = prio_q;
   assign o_dest_valid = (state_q == ST_ROUTE);
   assign o_drop       = (state_q == ST_DROP);
   assign o_dec_error  = err_q;
   assign o_err_cnt    = cnt_q;

endmodule

// File: tb/tb_exa_crosb_vc_routing.sv
// Scoreboard bench for the VC routing unit: expected routes are queued at stimulus time and compared when the DUT requests or drops.
module tb_exa_crosb_vc_routing;
   import exanet_crosb_pkg::*;

   localparam int TW  = 3;
   localparam int ON  = 8;
   localparam int MP  = 32;
   localparam int NVC = 2;
   localparam int ECW = 16;

   localparam logic [41:0] LOW  [MP] = '{0: 42'h0000, 1: 42'h1000, 2: 42'h2000, 3: 42'h2800,
                                        default: 42'h3FF_FFFF_FFFF};
   localparam logic [41:0] HIGH [MP] = '{0: 42'h0FFF, 1: 42'h1FFF, 2: 42'h2FFF, 3: 42'h3FFF,
                                        default: 42'h0};

   typedef struct packed {
      logic         drop;
      logic [2:0]   tdest;
      logic         vc;
      logic         prio;
      logic [127:0] hdr;
   } exp_t;

   logic              Clk = 1'b0;
   logic              Resetn;
   logic [127:0]      i_header;
   logic              i_hdr_valid;
   logic [21:0]       i_src_coord;
   cntrl_info_t       i_cntrl_info;
   logic [ON-1:0]     i_port_busy;
   logic              i_dest_ready, i_pkt_done, i_err_clr;
   logic [127:0]      o_header;
   logic [TW-1:0]     o_tdest;
   logic              o_vc;
   logic              o_prio, o_dest_valid, o_drop, o_dec_error;
   logic [ECW-1:0]    o_err_cnt;

   exp_t sb[$];
   int   n_chk   = 0;
   int   n_pass  = 0;
   int   exp_cnt = 0;

   always #5 Clk = ~Clk;

   exa_crosb_vc_routing #(
      .TDEST_WIDTH(TW), .OUTPUT_NUM(ON), .MAX_PORTS(MP),
      .PORT_LOW_ADDR(LOW), .PORT_HIGH_ADDR(HIGH),
      .NUM_VC(NVC), .ADAPTIVE_EN(1'b1), .ERR_CNT_WIDTH(ECW)
   ) dut (
      .Clk(Clk), .Resetn(Resetn), .i_header(i_header), .i_hdr_valid(i_hdr_valid),
      .i_src_coord(i_src_coord), .i_cntrl_info(i_cntrl_info), .i_port_busy(i_port_busy),
      .i_dest_ready(i_dest_ready), .i_pkt_done(i_pkt_done), .i_err_clr(i_err_clr),
      .o_header(o_header), .o_tdest(o_tdest), .o_vc(o_vc), .o_prio(o_prio),
      .o_dest_valid(o_dest_valid), .o_drop(o_drop), .o_dec_error(o_dec_error),
      .o_err_cnt(o_err_cnt)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   function automatic logic [127:0] mk_hdr(input logic [4:0] ptype, input logic [3:0] dx,
                                           input logic [3:0] dy, input logic [1:0] doff,
                                           input logic [2:0] path, input logic [41:0] va);
      logic [127:0] h;
      h           = '0;
      h[127:112]  = 16'hA5C3;
      h[12:8]     = ptype;
      h[24:21]    = dx;
      h[28:25]    = dy;
      h[34:33]    = doff;
      h[76:35]    = va;
      h[111:109]  = path;
      return h;
   endfunction

   function automatic exp_t mk_exp(input logic drop, input logic [2:0] tdest, input logic vc,
                                   input logic prio, input logic [127:0] hdr, input logic [2:0] path);
      exp_t e;
      e.drop           = drop;
      e.tdest          = tdest;
      e.vc             = vc;
      e.prio           = prio;
      e.hdr            = hdr;
      e.hdr[111:109]   = path;
      return e;
   endfunction

   function automatic cntrl_info_t mk_ci(input router_mode_e m, input logic mp);
      cntrl_info_t c;
      c.mode             = m;
      c.multipath_enable = mp;
      c.local_port       = 3'd1;
      c.dest_y_port      = 3'd7;
      c.dest_x_port      = {3'd6, 3'd5, 3'd4, 3'd3};
      return c;
   endfunction

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // same: ready and done in one cycle; stop: leave the packet parked in HOLD.
   task automatic run_pkt(input logic [127:0] hdr, input cntrl_info_t ci, input logic [ON-1:0] busy,
                          input exp_t e, input bit same, input bit stop);
      int   lat;
      exp_t x;
      i_header     = hdr;
      i_cntrl_info = ci;
      i_port_busy  = busy;
      i_hdr_valid  = 1'b1;
      sb.push_back(e);
      if (e.drop) exp_cnt++;
      lat = 0;
      while (!(o_dest_valid || o_drop) && lat < 10) begin
         step();
         lat++;
      end
      i_hdr_valid = 1'b0;
      i_err_clr   = 1'b0;
      chk("latency", 128'(lat), 128'd2);
      x = sb.pop_front();
      chk("drop", 128'(o_drop), 128'(x.drop));
      chk("dest_valid", 128'(o_dest_valid), 128'(!x.drop));
      if (x.drop) begin
         chk("dec_error", 128'(o_dec_error), 128'd1);
         chk("err_cnt", 128'(o_err_cnt), 128'(exp_cnt));
         i_pkt_done = 1'b1;
         step();
         i_pkt_done = 1'b0;
         chk("drop_end", 128'(o_drop), 128'd0);
      end else begin
         chk("tdest", 128'(o_tdest), 128'(x.tdest));
         chk("vc", 128'(o_vc), 128'(x.vc));
         chk("prio", 128'(o_prio), 128'(x.prio));
         chk("header", o_header, x.hdr);
         step();
         chk("valid_wait", 128'(o_dest_valid), 128'd1);
         i_dest_ready = 1'b1;
         i_pkt_done   = same;
         step();
         i_dest_ready = 1'b0;
         i_pkt_done   = 1'b0;
         chk("valid_after_ready", 128'(o_dest_valid), 128'd0);
         if (!same) begin
            i_port_busy = ~busy;
            step();
            chk("hold_tdest", 128'(o_tdest), 128'(x.tdest));
            chk("hold_header", o_header, x.hdr);
            if (!stop) begin
               i_pkt_done = 1'b1;
               step();
               i_pkt_done = 1'b0;
            end
         end
      end
   endtask

   initial begin
      logic [127:0] h;
      Resetn       = 1'b0;
      i_header     = '0;
      i_hdr_valid  = 1'b0;
      i_src_coord  = {8'd0, 2'd1, 4'd0, 4'd2, 4'd1};   // x=1 y=2 z=0 off=1
      i_cntrl_info = mk_ci(MODE_NI, 1'b0);
      i_port_busy  = '0;
      i_dest_ready = 1'b0;
      i_pkt_done   = 1'b0;
      i_err_clr    = 1'b0;
      repeat (3) step();
      chk("rst_valid", 128'(o_dest_valid), 128'd0);
      chk("rst_drop", 128'(o_drop), 128'd0);
      chk("rst_tdest", 128'(o_tdest), 128'd0);
      chk("rst_header", o_header, 128'd0);
      chk("rst_err_cnt", 128'(o_err_cnt), 128'd0);
      @(negedge Clk) Resetn = 1'b1;
      step();

      // NI address windows
      h = mk_hdr(5'd3, 4'd1, 4'd2, 2'd1, 3'd0, 42'h2100);
      run_pkt(h, mk_ci(MODE_NI, 1'b0), '0, mk_exp(1'b0, 3'd2, 1'b0, 1'b0, h, 3'd0), 1'b0, 1'b0);
      h = mk_hdr(5'd3, 4'd1, 4'd2, 2'd1, 3'd0, 42'h2900);
      run_pkt(h, mk_ci(MODE_NI, 1'b0), '0, mk_exp(1'b0, 3'd3, 1'b0, 1'b0, h, 3'd0), 1'b1, 1'b0);
      h = mk_hdr(5'd3, 4'd1, 4'd2, 2'd1, 3'd0, 42'h1000);
      run_pkt(h, mk_ci(MODE_NI, 1'b0), '0, mk_exp(1'b0, 3'd1, 1'b0, 1'b0, h, 3'd0), 1'b0, 1'b0);
      h = mk_hdr(5'd3, 4'd1, 4'd2, 2'd1, 3'd0, 42'h1FFF);
      run_pkt(h, mk_ci(MODE_NI, 1'b0), '0, mk_exp(1'b0, 3'd1, 1'b0, 1'b0, h, 3'd0), 1'b0, 1'b0);
      h = mk_hdr(5'd3, 4'd4, 4'd2, 2'd1, 3'd0, 42'h2100);
      run_pkt(h, mk_ci(MODE_NI, 1'b0), '0, mk_exp(1'b0, 3'd0, 1'b0, 1'b0, h, 3'd0), 1'b0, 1'b0);
      h = mk_hdr(5'd3, 4'd1, 4'd2, 2'd2, 3'd0, 42'h3000);
      run_pkt(h, mk_ci(MODE_NI, 1'b0), '0, mk_exp(1'b0, 3'd2, 1'b0, 1'b0, h, 3'd0), 1'b0, 1'b0);

      // Inter router adaptive diversion: y busy, x0 busy -> x1, then pointer continues at x2
      h = mk_hdr(5'd3, 4'd1, 4'd3, 2'd0, 3'd0, 42'h0);
      run_pkt(h, mk_ci(MODE_INTER, 1'b1), 8'h88, mk_exp(1'b0, 3'd4, 1'b1, 1'b0, h, 3'd2), 1'b0, 1'b0);
      run_pkt(h, mk_ci(MODE_INTER, 1'b1), 8'h80, mk_exp(1'b0, 3'd5, 1'b1, 1'b0, h, 3'd3), 1'b0, 1'b0);
      run_pkt(h, mk_ci(MODE_INTER, 1'b1), 8'hF8, mk_exp(1'b0, 3'd7, 1'b0, 1'b0, h, 3'd0), 1'b0, 1'b0);
      h = mk_hdr(5'd3, 4'd1, 4'd3, 2'd0, 3'd2, 42'h0);
      run_pkt(h, mk_ci(MODE_INTER, 1'b1), '0, mk_exp(1'b0, 3'd4, 1'b1, 1'b0, h, 3'd0), 1'b0, 1'b0);

      // Central router, priority threshold
      h = mk_hdr(5'd20, 4'd0, 4'd6, 2'd0, 3'd0, 42'h0);
      run_pkt(h, mk_ci(MODE_CENTRAL, 1'b0), '0, mk_exp(1'b0, 3'd6, 1'b1, 1'b1, h, 3'd0), 1'b0, 1'b0);
      h = mk_hdr(5'd16, 4'd0, 4'd2, 2'd0, 3'd0, 42'h0);
      run_pkt(h, mk_ci(MODE_CENTRAL, 1'b0), '0, mk_exp(1'b0, 3'd2, 1'b0, 1'b0, h, 3'd0), 1'b0, 1'b0);

      // Decode errors, sticky flag and clear
      h = mk_hdr(5'd3, 4'd1, 4'd2, 2'd1, 3'd0, 42'h5000);
      run_pkt(h, mk_ci(MODE_NI, 1'b0), '0, mk_exp(1'b1, 3'd0, 1'b0, 1'b0, h, 3'd0), 1'b0, 1'b0);
      i_err_clr = 1'b1;
      step();
      i_err_clr = 1'b0;
      chk("err_cleared", 128'(o_dec_error), 128'd0);
      i_err_clr = 1'b1;
      run_pkt(h, mk_ci(MODE_NI, 1'b0), '0, mk_exp(1'b1, 3'd0, 1'b0, 1'b0, h, 3'd0), 1'b0, 1'b0);
      h = mk_hdr(5'd3, 4'd6, 4'd2, 2'd0, 3'd0, 42'h0);
      run_pkt(h, mk_ci(MODE_INTER, 1'b0), '0, mk_exp(1'b1, 3'd0, 1'b0, 1'b0, h, 3'd0), 1'b0, 1'b0);

      // Local delivery parked in HOLD, then asynchronous reset
      h = mk_hdr(5'd3, 4'd1, 4'd2, 2'd2, 3'd5, 42'h0);
      run_pkt(h, mk_ci(MODE_INTER, 1'b0), '0, mk_exp(1'b0, 3'd3, 1'b1, 1'b0, h, 3'd5), 1'b0, 1'b1);
      Resetn = 1'b0;
      #2;
      chk("arst_tdest", 128'(o_tdest), 128'd0);
      chk("arst_vc", 128'(o_vc), 128'd0);
      chk("arst_header", o_header, 128'd0);
      chk("arst_dec_error", 128'(o_dec_error), 128'd0);
      chk("arst_err_cnt", 128'(o_err_cnt), 128'd0);
      exp_cnt = 0;
      @(negedge Clk) Resetn = 1'b1;
      step();
      h = mk_hdr(5'd3, 4'd1, 4'd2, 2'd1, 3'd0, 42'h2100);
      run_pkt(h, mk_ci(MODE_NI, 1'b0), '0, mk_exp(1'b0, 3'd2, 1'b0, 1'b0, h, 3'd0), 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
